// File: rtl/lsu.sv
// lsu: load/store unit FSM bridging decode to a valid/ready data bus; define LSU_MISALIGN_CHK_EN to abort misaligned word accesses
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wmask,
  input  logic        is_lbu,
  input  logic        is_sb,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        lsu_done,
  output logic        lsu_wen,
  output logic [4:0]  lsu_rd,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        lsu_busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  bsel;
  logic        lbu_q;
  logic [4:0]  rd_q;
  logic        misalign;
  assign lsu_ready      = state == IDLE;
  assign lsu_busy       = state != IDLE;
  assign dmem_req_valid = state == REQ;
`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = (mem_wen ? !is_sb : !is_lbu) && (mem_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  // access sequencing: latch on accept, bus handshake, response or timeout, one-cycle completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bsel       <= '0;
      lbu_q      <= 1'b0;
      rd_q       <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wmask <= '0;
      lsu_done   <= 1'b0;
      lsu_wen    <= 1'b0;
      lsu_err    <= 1'b0;
      lsu_rd     <= '0;
      lsu_rdata  <= '0;
    end else begin
      lsu_done <= 1'b0;
      lsu_wen  <= 1'b0;
      lsu_err  <= 1'b0;
      case (state)
        IDLE: if (lsu_valid) begin
          dmem_we    <= mem_wen;
          dmem_addr  <= {mem_addr[31:2], 2'b00};
          dmem_wdata <= is_sb ? {4{rs2_data[7:0]}} : rs2_data;
          dmem_wmask <= mem_wen ? mem_wmask : 4'b0000;
          bsel       <= mem_addr[1:0];
          lbu_q      <= is_lbu;
          rd_q       <= rd_addr;
          if (misalign) begin
            state    <= DONE;
            lsu_done <= 1'b1;
            lsu_err  <= 1'b1;
            lsu_rd   <= rd_addr;
          end else begin
            state <= REQ;
          end
        end
        REQ: if (dmem_req_ready) begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: if (dmem_rsp_valid) begin
          state    <= DONE;
          lsu_done <= 1'b1;
          lsu_wen  <= !dmem_we;
          lsu_rd   <= rd_q;
          if (!dmem_we) lsu_rdata <= lbu_q ? {24'b0, dmem_rdata[{bsel, 3'b000} +: 8]} : dmem_rdata;
        end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          state    <= DONE;
          lsu_done <= 1'b1;
          lsu_err  <= 1'b1;
          lsu_rd   <= rd_q;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized and directed self-checking bench for lsu against a transaction-level model
module tb_lsu;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic lsu_valid = 0, lsu_ready, mem_wen = 0, is_lbu = 0, is_sb = 0;
  logic [31:0] mem_addr = 0, rs2_data = 0, dmem_addr, dmem_wdata, dmem_rdata = 0, lsu_rdata;
  logic [3:0] mem_wmask = 0, dmem_wmask;
  logic [4:0] rd_addr = 0, lsu_rd;
  logic dmem_req_valid, dmem_req_ready = 0, dmem_we, dmem_rsp_valid = 0;
  logic lsu_done, lsu_wen, lsu_err, lsu_busy;
  int total = 0, bad = 0;
  int o_done_cyc, o_dones, o_reqn;
  logic o_wen, o_err, o_unstable, o_after_ok, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0] o_wmask;
  logic [4:0] o_rd;
  int e_cyc, e_reqn;
  logic e_err, e_wen, e_we;
  logic [31:0] e_rdata, e_addr, e_wdata, prev_rdata = 0;
  logic [3:0] e_wmask;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .is_lbu(is_lbu),
    .is_sb(is_sb), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .lsu_done(lsu_done), .lsu_wen(lsu_wen), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .lsu_busy(lsu_busy)
  );

  always #5 clk = ~clk;

  task automatic model(input logic wen, input logic [31:0] addr, input logic [3:0] wmask,
                       input logic lbu, input logic sb, input logic [31:0] rs2,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
    logic mis, ok;
`ifdef LSU_MISALIGN_CHK_EN
    mis = (wen ? !sb : !lbu) && addr[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    ok = !mis && rsp_dly >= 0 && rsp_dly < TO;
    e_cyc = mis ? 1 : 2 + rdy_dly + (ok ? rsp_dly + 1 : TO);
    e_reqn = mis ? 0 : rdy_dly + 1;
    e_err = !ok;
    e_wen = ok && !wen;
    e_rdata = e_wen ? (lbu ? ((rdata >> (8 * addr[1:0])) & 32'hFF) : rdata) : prev_rdata;
    prev_rdata = e_rdata;
    e_we = wen;
    e_addr = addr & 32'hFFFF_FFFC;
    e_wdata = sb ? {4{rs2[7:0]}} : rs2;
    e_wmask = wen ? wmask : 4'b0000;
  endtask

  task automatic run(input logic wen, input logic [31:0] addr, input logic [3:0] wmask,
                     input logic lbu, input logic sb, input logic [31:0] rs2, input logic [4:0] rd,
                     input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
    logic hs, seen;
    int wn;
    @(negedge clk);
    lsu_valid = 1; mem_wen = wen; mem_addr = addr; mem_wmask = wmask; is_lbu = lbu; is_sb = sb;
    rs2_data = rs2; rd_addr = rd; dmem_req_ready = 0; dmem_rsp_valid = 0;
    o_done_cyc = -1; o_dones = 0; o_reqn = 0; o_unstable = 0; o_after_ok = 0;
    hs = 0; seen = 0; wn = 0;
    for (int cyc = 1; cyc < 600; cyc++) begin
      @(negedge clk);
      if (seen) begin
        o_after_ok = lsu_ready && !lsu_busy && !lsu_done && !dmem_req_valid;
        break;
      end
      if (lsu_done) begin
        o_dones++; o_done_cyc = cyc; o_wen = lsu_wen; o_err = lsu_err; o_rdata = lsu_rdata; o_rd = lsu_rd;
        seen = 1;
      end
      if (dmem_req_valid) begin
        if (o_reqn == 0) {o_we, o_addr, o_wdata, o_wmask} = {dmem_we, dmem_addr, dmem_wdata, dmem_wmask};
        else if ({o_we, o_addr, o_wdata, o_wmask} !== {dmem_we, dmem_addr, dmem_wdata, dmem_wmask}) o_unstable = 1;
        o_reqn++;
      end
      lsu_valid = seen ? 1'b0 : 1'($urandom);
      mem_wen = 1'($urandom); mem_addr = $urandom; mem_wmask = 4'($urandom); is_lbu = 1'($urandom);
      is_sb = 1'($urandom); rs2_data = $urandom; rd_addr = 5'($urandom);
      dmem_rdata = $urandom; dmem_rsp_valid = 1'($urandom); dmem_req_ready = 0;
      if (dmem_req_valid) begin
        dmem_req_ready = o_reqn > rdy_dly;
        hs = hs | dmem_req_ready;
      end else if (hs && !seen) begin
        dmem_rsp_valid = wn == rsp_dly;
        if (dmem_rsp_valid) dmem_rdata = rdata;
        wn++;
      end
    end
    lsu_valid = 0; dmem_rsp_valid = 0; dmem_req_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", lsu_ready); end
    total++; if ({lsu_busy, dmem_req_valid, dmem_we, lsu_done, lsu_wen, lsu_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {lsu_busy, dmem_req_valid, dmem_we, lsu_done, lsu_wen, lsu_err}); end
    total++; if ({dmem_addr, dmem_wdata, dmem_wmask, lsu_rd, lsu_rdata} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0", dmem_addr, dmem_wdata, dmem_wmask, lsu_rd, lsu_rdata); end
    rst = 0;
    prev_rdata = 0;
  endtask

  task automatic test_lw;
    model(0, 32'h8000_0004, 4'h0, 0, 0, 32'h0, 0, 0, 32'h1234_5678);
    run(0, 32'h8000_0004, 4'h0, 0, 0, 32'h0, 5'd7, 0, 0, 32'h1234_5678);
    total++; if (o_done_cyc !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", o_done_cyc); end
    total++; if (o_wen !== 1'b1 || o_err !== 1'b0) begin bad++; $display("FAIL lw_wen_err got=%b%b exp=10", o_wen, o_err); end
    total++; if (o_rdata !== 32'h1234_5678) begin bad++; $display("FAIL lw_rdata got=%h exp=12345678", o_rdata); end
    total++; if (o_rd !== 5'd7) begin bad++; $display("FAIL lw_rd got=%0d exp=7", o_rd); end
    total++; if (o_addr !== 32'h8000_0004 || o_wmask !== 4'b0 || o_we !== 1'b0) begin
      bad++; $display("FAIL lw_bus got=%h/%b/%b exp=80000004/0000/0", o_addr, o_wmask, o_we); end
    total++; if (o_dones !== 1 || !o_after_ok) begin bad++; $display("FAIL lw_done_pulse got=%0d/%b exp=1/1", o_dones, o_after_ok); end
  endtask

  task automatic test_lbu;
    model(0, 32'h8000_0003, 4'h0, 1, 0, 32'h0, 0, 0, 32'hAABB_CCDD);
    run(0, 32'h8000_0003, 4'h0, 1, 0, 32'h0, 5'd9, 0, 0, 32'hAABB_CCDD);
    total++; if (o_rdata !== 32'h0000_00AA) begin bad++; $display("FAIL lbu_rdata got=%h exp=000000aa", o_rdata); end
    total++; if (o_wen !== 1'b1 || o_addr !== 32'h8000_0000) begin bad++; $display("FAIL lbu_wen_addr got=%b/%h exp=1/80000000", o_wen, o_addr); end
  endtask

  task automatic test_sb;
    model(1, 32'h8000_0002, 4'b0100, 0, 1, 32'hEF, 0, 0, 32'h0);
    run(1, 32'h8000_0002, 4'b0100, 0, 1, 32'hEF, 5'd3, 0, 0, 32'h0);
    total++; if (o_wdata !== 32'hEFEF_EFEF) begin bad++; $display("FAIL sb_wdata got=%h exp=efefefef", o_wdata); end
    total++; if (o_wmask !== 4'b0100 || o_we !== 1'b1) begin bad++; $display("FAIL sb_wmask got=%b/%b exp=0100/1", o_wmask, o_we); end
    total++; if (o_addr !== 32'h8000_0000) begin bad++; $display("FAIL sb_addr got=%h exp=80000000", o_addr); end
    total++; if (o_wen !== 1'b0 || o_err !== 1'b0 || o_done_cyc !== 3) begin
      bad++; $display("FAIL sb_done got=%b/%b/%0d exp=0/0/3", o_wen, o_err, o_done_cyc); end
    total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL sb_rdata_hold got=%h exp=%h", o_rdata, e_rdata); end
  endtask

  task automatic test_timeout;
    model(0, 32'h8000_0010, 4'h0, 0, 0, 32'h0, 4, -1, 32'h0);
    run(0, 32'h8000_0010, 4'h0, 0, 0, 32'h0, 5'd5, 4, -1, 32'h0);
    total++; if (o_reqn !== 5 || o_unstable) begin bad++; $display("FAIL to_req_hold got=%0d/%b exp=5/0", o_reqn, o_unstable); end
    total++; if (o_err !== 1'b1 || o_wen !== 1'b0) begin bad++; $display("FAIL to_err got=%b/%b exp=1/0", o_err, o_wen); end
    total++; if (o_done_cyc !== e_cyc) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", o_done_cyc, e_cyc); end
    total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL to_rdata_hold got=%h exp=%h", o_rdata, e_rdata); end
    model(0, 32'h8000_0020, 4'h0, 0, 0, 32'h0, 0, TO - 1, 32'h5A5A_0001);
    run(0, 32'h8000_0020, 4'h0, 0, 0, 32'h0, 5'd1, 0, TO - 1, 32'h5A5A_0001);
    total++; if (o_err !== 1'b0 || o_wen !== 1'b1 || o_rdata !== 32'h5A5A_0001) begin
      bad++; $display("FAIL rsp_vs_timeout got=%b/%b/%h exp=0/1/5a5a0001", o_err, o_wen, o_rdata); end
    total++; if (o_done_cyc !== 6) begin bad++; $display("FAIL rsp_vs_timeout_lat got=%0d exp=6", o_done_cyc); end
  endtask

  task automatic test_misalign;
    model(1, 32'h8000_0001, 4'hF, 0, 0, 32'hCAFE_F00D, 0, 0, 32'h0);
    run(1, 32'h8000_0001, 4'hF, 0, 0, 32'hCAFE_F00D, 5'd2, 0, 0, 32'h0);
`ifdef LSU_MISALIGN_CHK_EN
    total++; if (o_done_cyc !== 1 || o_err !== 1'b1 || o_wen !== 1'b0) begin
      bad++; $display("FAIL misalign_done got=%0d/%b/%b exp=1/1/0", o_done_cyc, o_err, o_wen); end
    total++; if (o_reqn !== 0) begin bad++; $display("FAIL misalign_noreq got=%0d exp=0", o_reqn); end
`else
    total++; if (o_done_cyc !== 3 || o_err !== 1'b0) begin bad++; $display("FAIL misalign_off got=%0d/%b exp=3/0", o_done_cyc, o_err); end
    total++; if (o_addr !== 32'h8000_0000 || o_wdata !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL misalign_off_bus got=%h/%h exp=80000000/cafef00d", o_addr, o_wdata); end
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic wen, lbu, sb;
      logic [31:0] addr, rs2, rdata;
      logic [3:0] wmask;
      logic [4:0] rd;
      int rdy, rsp;
      wen = 1'($urandom); lbu = wen ? 1'b0 : 1'($urandom); sb = wen ? 1'($urandom) : 1'b0;
      addr = $urandom; rs2 = $urandom; rdata = $urandom; rd = 5'($urandom);
      wmask = sb ? 4'(1 << addr[1:0]) : 4'hF;
      rdy = $urandom_range(0, 6); rsp = $urandom_range(0, TO + 1);
      model(wen, addr, wmask, lbu, sb, rs2, rdy, rsp, rdata);
      run(wen, addr, wmask, lbu, sb, rs2, rd, rdy, rsp, rdata);
      total++; if (o_done_cyc !== e_cyc) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, o_done_cyc, e_cyc); end
      total++; if ({o_err, o_wen} !== {e_err, e_wen}) begin bad++; $display("FAIL rnd%0d_err_wen got=%b%b exp=%b%b", i, o_err, o_wen, e_err, e_wen); end
      total++; if (o_rdata !== e_rdata || o_rd !== rd) begin bad++; $display("FAIL rnd%0d_wb got=%h/%0d exp=%h/%0d", i, o_rdata, o_rd, e_rdata, rd); end
      total++; if (o_reqn !== e_reqn || o_unstable) begin bad++; $display("FAIL rnd%0d_req got=%0d/%b exp=%0d/0", i, o_reqn, o_unstable, e_reqn); end
      if (e_reqn > 0) begin
        total++; if ({o_we, o_addr, o_wdata, o_wmask} !== {e_we, e_addr, e_wdata, e_wmask}) begin
          bad++; $display("FAIL rnd%0d_bus got=%b/%h/%h/%b exp=%b/%h/%h/%b", i, o_we, o_addr, o_wdata, o_wmask, e_we, e_addr, e_wdata, e_wmask); end
      end
      total++; if (o_dones !== 1 || !o_after_ok) begin bad++; $display("FAIL rnd%0d_pulse got=%0d/%b exp=1/1", i, o_dones, o_after_ok); end
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    @(negedge clk);
    lsu_valid = 1; mem_wen = 0; mem_addr = 32'h8000_0040; is_lbu = 0; is_sb = 0; rd_addr = 5'd4;
    @(negedge clk);
    lsu_valid = 0; dmem_req_ready = 1;
    @(negedge clk);
    dmem_req_ready = 0; rst = 1;
    @(negedge clk);
    total++; if (lsu_ready !== 1'b1 || dmem_req_valid !== 1'b0 || lsu_done !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=%b/%b/%b exp=1/0/0", lsu_ready, dmem_req_valid, lsu_done); end
    rst = 0; dmem_rsp_valid = 1; dmem_rdata = 32'hDEAD_BEEF; dones = 0;
    repeat (5) begin @(negedge clk); dones += int'(lsu_done); end
    dmem_rsp_valid = 0;
    total++; if (dones !== 0 || lsu_rdata !== 32'h0) begin bad++; $display("FAIL rst_mid_nodone got=%0d/%h exp=0/0", dones, lsu_rdata); end
    prev_rdata = 0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lbu();
    test_sb();
    test_timeout();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
